// File: rtl/silencer.sv
// Per-channel duty step limiter: walks each channel toward its new target by at most STEP
// counts per update, one channel per clock through a shared compare/add datapath.
module silencer #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 10
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] STEP,
  input  logic [WIDTH-1:0] DUTY_IN  [0:DEPTH-1],
  input  logic             IN_VALID,
  output logic [WIDTH-1:0] DUTY_OUT [0:DEPTH-1],
  output logic             OUT_VALID,
  output logic             BUSY
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] step_q, step_d;
  logic [WIDTH-1:0] target_q   [0:DEPTH-1];
  logic [WIDTH-1:0] target_d   [0:DEPTH-1];
  logic [WIDTH-1:0] cur_q      [0:DEPTH-1];
  logic [WIDTH-1:0] cur_d      [0:DEPTH-1];
  logic [WIDTH-1:0] pend_q     [0:DEPTH-1];
  logic [WIDTH-1:0] pend_d     [0:DEPTH-1];
  logic [WIDTH-1:0] duty_out_q [0:DEPTH-1];
  logic [WIDTH-1:0] duty_out_d [0:DEPTH-1];
  logic             pend_flag_q, pend_flag_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH-1:0]        tgt_k, cur_k, next_k;
  logic signed [WIDTH:0]   diff;
  logic [WIDTH:0]          abs_diff;

  // Shared datapath: the result always lies between cur and target, so no wrap is possible.
  always_comb begin
    tgt_k    = target_q[idx_q];
    cur_k    = cur_q[idx_q];
    diff     = $signed({1'b0, tgt_k}) - $signed({1'b0, cur_k});
    abs_diff = diff[WIDTH] ? $unsigned(-diff) : $unsigned(diff);
    if ((step_q == '0) || (abs_diff <= {1'b0, step_q})) begin
      next_k = tgt_k;
    end else if (!diff[WIDTH]) begin
      next_k = cur_k + step_q;
    end else begin
      next_k = cur_k - step_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    step_d      = step_q;
    target_d    = target_q;
    cur_d       = cur_q;
    pend_d      = pend_q;
    pend_flag_d = pend_flag_q;
    duty_out_d  = duty_out_q;
    out_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (IN_VALID) begin
          target_d = DUTY_IN;
          step_d   = STEP;
          idx_d    = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        cur_d[idx_q] = next_k;
        if (IN_VALID) begin
          pend_d      = DUTY_IN;
          pend_flag_d = 1'b1;
        end
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_DONE: begin
        duty_out_d  = cur_q;
        out_valid_d = 1'b1;
        // A strobe arriving in this very cycle is newer than anything pending.
        if (IN_VALID || pend_flag_q) begin
          if (IN_VALID) begin
            target_d = DUTY_IN;
          end else begin
            target_d = pend_q;
          end
          pend_flag_d = 1'b0;
          step_d      = STEP;
          idx_d       = '0;
          state_d     = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      step_q      <= '0;
      target_q    <= '{default: '0};
      cur_q       <= '{default: '0};
      pend_q      <= '{default: '0};
      duty_out_q  <= '{default: '0};
      pend_flag_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      step_q      <= step_d;
      target_q    <= target_d;
      cur_q       <= cur_d;
      pend_q      <= pend_d;
      duty_out_q  <= duty_out_d;
      pend_flag_q <= pend_flag_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign DUTY_OUT  = duty_out_q;
  assign OUT_VALID = out_valid_q;
  assign BUSY      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_silencer.sv
// Bench for silencer: a transaction-level model predicts every output each cycle, and
// directed scenarios pin the model with hand-computed values.
module tb_silencer;
  localparam int WIDTH = 13;
  localparam int DEPTH = 10;
  localparam int LAT   = DEPTH + 1;

  logic             CLK = 1'b0;
  logic             RST_N = 1'b0;
  logic [WIDTH-1:0] step = '0;
  logic [WIDTH-1:0] duty_in  [0:DEPTH-1];
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] duty_out [0:DEPTH-1];
  logic             out_valid;
  logic             busy;

  int testsRun = 0;
  int testsFailed = 0;
  bit checkEn = 1'b0;

  always #10 CLK = ~CLK;

  silencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST_N(RST_N), .STEP(step), .DUTY_IN(duty_in), .IN_VALID(in_valid),
    .DUTY_OUT(duty_out), .OUT_VALID(out_valid), .BUSY(busy)
  );

  // Model: a run's whole result is computed the moment it starts and revealed LAT edges later.
  int mCur [DEPTH];
  int mOut [DEPTH];
  int mPend [DEPTH];
  int src [DEPTH];
  bit mHavePend = 1'b0;
  bit mActive = 1'b0;
  bit expValid = 1'b0;
  bit doStart;
  int mEnd = 0;
  int cyc = 0;

  function automatic int moveToward(input int c, input int t, input int s);
    int d;
    d = t - c;
    if (s == 0 || (d <= s && -d <= s)) return t;
    return (d > 0) ? c + s : c - s;
  endfunction

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        mCur[i] = 0; mOut[i] = 0; mPend[i] = 0;
      end
      mHavePend = 1'b0; mActive = 1'b0; expValid = 1'b0; mEnd = 0;
    end else begin
      cyc++;
      expValid = 1'b0;
      doStart  = 1'b0;
      if (mActive && cyc == mEnd) begin
        for (int i = 0; i < DEPTH; i++) mOut[i] = mCur[i];
        expValid = 1'b1;
        mActive  = 1'b0;
        if (in_valid) begin
          for (int i = 0; i < DEPTH; i++) src[i] = int'(duty_in[i]);
          doStart = 1'b1;
        end else if (mHavePend) begin
          for (int i = 0; i < DEPTH; i++) src[i] = mPend[i];
          doStart = 1'b1;
        end
        mHavePend = 1'b0;
      end else if (mActive) begin
        if (in_valid) begin
          for (int i = 0; i < DEPTH; i++) mPend[i] = int'(duty_in[i]);
          mHavePend = 1'b1;
        end
      end else if (in_valid) begin
        for (int i = 0; i < DEPTH; i++) src[i] = int'(duty_in[i]);
        doStart = 1'b1;
      end
      if (doStart) begin
        for (int i = 0; i < DEPTH; i++) mCur[i] = moveToward(mCur[i], src[i], int'(step));
        mActive = 1'b1;
        mEnd    = cyc + LAT;
      end
    end
  end

  always @(negedge CLK) begin
    if (checkEn) begin
      testsRun++;
      if (out_valid !== expValid) begin
        testsFailed++;
        $display("[TB] FAIL outValid cyc %0d: got %b expected %b", cyc, out_valid, expValid);
      end
      testsRun++;
      if (busy !== mActive) begin
        testsFailed++;
        $display("[TB] FAIL busy cyc %0d: got %b expected %b", cyc, busy, mActive);
      end
      testsRun++;
      for (int i = 0; i < DEPTH; i++) begin
        if (duty_out[i] !== mOut[i][WIDTH-1:0]) begin
          testsFailed++;
          $display("[TB] FAIL dutyOut[%0d] cyc %0d: got %0d expected %0d", i, cyc, duty_out[i], mOut[i]);
          break;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input int got, input int exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic pulseData(input int val);
    for (int i = 0; i < DEPTH; i++) duty_in[i] = WIDTH'(val);
    in_valid = 1'b1;
    @(negedge CLK);
    in_valid = 1'b0;
  endtask

  // Drives one strobe sampled at edge E; returns at the negedge just after E.
  task automatic applyStimulus(input int stepVal, input int val);
    @(negedge CLK);
    step = WIDTH'(stepVal);
    pulseData(val);
  endtask

  task automatic waitValid(output int lat, output int busyCnt);
    lat = -1;
    busyCnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) @(negedge CLK);
      if (busy) busyCnt++;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic countPulses(input int window, output int n, output int first, output int second,
                             output int firstDuty, output int secondDuty);
    n = 0; first = -1; second = -1; firstDuty = -1; secondDuty = -1;
    for (int k = 0; k < window; k++) begin
      if (k > 0) @(negedge CLK);
      if (out_valid) begin
        n++;
        if (n == 1) begin first = k; firstDuty = int'(duty_out[0]); end
        if (n == 2) begin second = k; secondDuty = int'(duty_out[DEPTH-1]); end
      end
    end
  endtask

  task automatic doReset();
    @(negedge CLK);
    #2 RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    #2 RST_N = 1'b1;
  endtask

  int lat, busyCnt, n, p1, p2, d1, d2;
  int rampExp [7] = '{100, 200, 250, 250, 150, 50, 0};
  int mixTgt [4] = '{5, 4095, 0, 10};
  int mixExp [4] = '{5, 10, 0, 10};
  int sel;

  initial begin
    for (int i = 0; i < DEPTH; i++) duty_in[i] = '0;
    repeat (3) @(negedge CLK);
    #2 RST_N = 1'b1;
    checkEn = 1'b1;
    #1;
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset outValid", int'(out_valid), 0);
    checkOutput("reset dutyOut", int'(duty_out[0]), 0);

    // Bypass: latency and busy width.
    applyStimulus(0, 2500);
    waitValid(lat, busyCnt);
    checkOutput("bypass latency", lat, 11);
    checkOutput("bypass busy cycles", busyCnt, 11);
    checkOutput("bypass duty0", int'(duty_out[0]), 2500);
    checkOutput("bypass duty9", int'(duty_out[DEPTH-1]), 2500);

    // Ramp up then down with STEP=100.
    doReset();
    for (int r = 0; r < 7; r++) begin
      applyStimulus(100, (r < 4) ? 250 : 0);
      waitValid(lat, busyCnt);
      checkOutput($sformatf("ramp update %0d", r), int'(duty_out[3]), rampExp[r]);
    end

    // Mixed channels and WIDTH-boundary clamps.
    doReset();
    @(negedge CLK);
    step = WIDTH'(10);
    for (int i = 0; i < DEPTH; i++) duty_in[i] = (i < 4) ? WIDTH'(mixTgt[i]) : WIDTH'(8191);
    in_valid = 1'b1;
    @(negedge CLK);
    in_valid = 1'b0;
    waitValid(lat, busyCnt);
    for (int i = 0; i < 4; i++) checkOutput($sformatf("mixed ch%0d", i), int'(duty_out[i]), mixExp[i]);
    applyStimulus(0, 8191);
    waitValid(lat, busyCnt);
    applyStimulus(10, 0);
    waitValid(lat, busyCnt);
    checkOutput("clamp down from max", int'(duty_out[0]), 8181);
    applyStimulus(8180, 0);
    waitValid(lat, busyCnt);
    checkOutput("clamp large step", int'(duty_out[0]), 1);

    // Two strobes during RUN: only the newest survives.
    applyStimulus(0, 1000);
    repeat (2) @(negedge CLK);
    pulseData(1111);
    @(negedge CLK);
    pulseData(2222);
    countPulses(40, n, p1, p2, d1, d2);
    checkOutput("pend pulses", n, 2);
    checkOutput("pend spacing", p2 - p1, 11);
    checkOutput("pend first data", d1, 1000);
    checkOutput("pend second data", d2, 2222);

    // Strobe coincident with DONE beats the pending data.
    applyStimulus(0, 3000);
    repeat (2) @(negedge CLK);
    pulseData(3333);
    repeat (7) @(negedge CLK);
    pulseData(4444);
    countPulses(40, n, p1, p2, d1, d2);
    checkOutput("done pulses", n, 2);
    checkOutput("done spacing", p2 - p1, 11);
    checkOutput("done second data", d2, 4444);

    // Reset mid-run aborts it.
    applyStimulus(0, 3000);
    repeat (3) @(negedge CLK);
    #2 RST_N = 1'b0;
    #1;
    checkOutput("abort dutyOut", int'(duty_out[0]), 0);
    checkOutput("abort busy", int'(busy), 0);
    @(negedge CLK);
    #2 RST_N = 1'b1;
    countPulses(20, n, p1, p2, d1, d2);
    checkOutput("abort no pulse", n, 0);
    applyStimulus(100, 250);
    waitValid(lat, busyCnt);
    checkOutput("after abort ramp", int'(duty_out[0]), 100);

    // Random traffic against the model.
    for (int it = 0; it < 2000; it++) begin
      @(negedge CLK);
      if ($urandom_range(0, (it < 1000) ? 6 : 20) == 0) begin
        sel = $urandom_range(0, 3);
        step = (sel == 0) ? '0 : (sel == 1) ? WIDTH'($urandom_range(1, 64)) :
               (sel == 2) ? WIDTH'($urandom_range(0, 8191)) : WIDTH'(8191);
        for (int i = 0; i < DEPTH; i++) begin
          sel = $urandom_range(0, 5);
          duty_in[i] = (sel == 0) ? '0 : (sel == 1) ? WIDTH'(8191) : WIDTH'($urandom_range(0, 8191));
        end
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge CLK);
    in_valid = 1'b0;
    repeat (60) @(negedge CLK);
    checkOutput("final idle", int'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
